int2flt_seq: RTL and testbench
==============================

Name: int2flt_seq

Overview:
- Sequential converter from 16-bit sign-magnitude integer to IEEE-754 half-precision float (1 sign, 5 exponent, 10 mantissa bits).
- Its input format is exactly the sign-magnitude integer produced by flt2int: bit 15 is the sign, bits 14:0 are the magnitude.
- It sits alongside flt2int in the conversion datapath. The controller loads an operand, pulses start, and collects the result on done.
- Normalization is iterative, one left shift per cycle. Rounding is round-to-nearest-even.

Parameters:
- INT_W, 16, integer width including sign bit.
- EXP_W, 5, float exponent width.
- MANT_W, 10, float stored-mantissa width.
- BIAS, 15, exponent bias.
- Only the default parameter set is required to be supported and verified.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- reset_i  input  1  synchronous, active-low reset. Sampled on the rising edge of clk_i; 0 = reset.
- start_i  input  1  request conversion of int_i. Accepted only when busy_o=0.
- int_i  input  16  sign-magnitude integer: [15] sign, [14:0] magnitude. Sampled on the accepting edge only.
- busy_o  output  1  high from the accepting edge until the done edge, inclusive of all NORM and ROUND cycles.
- done_o  output  1  one-cycle pulse; flt_o is valid in that cycle.
- flt_o  output  16  half-float result. Holds its value until the next accepted start or reset.

Behaviour:
- Reset (reset_i=0 at a rising edge), from any state including mid-conversion:
  - state goes to IDLE;
  - busy_o=0, done_o=0, flt_o=16'h0000;
  - internal magnitude, exponent and sign registers are cleared;
  - any in-flight conversion is discarded, with no done pulse.
- States: IDLE, NORM, ROUND, DONE.
- IDLE, start_i=1:
  - latch sign=int_i[15], mag=int_i[14:0], exp=BIAS+14 (=29);
  - busy_o goes to 1;
  - if int_i[14:0]==0, go directly to DONE with flt_o={sign,15'b0}. This preserves signed zero.
  - otherwise go to NORM.
- IDLE, start_i=0: stay in IDLE.
- NORM, one cycle each:
  - if mag[14]==1, go to ROUND;
  - else mag<=mag<<1, exp<=exp-1, stay in NORM.
  - At most 14 shifts, so exp never drops below 15.
- ROUND (single cycle):
  - fields: m=mag[13:4], guard=mag[3], sticky=|mag[2:0]. mag[14] is the hidden bit.
  - round up if guard && (sticky || m[0]).
  - if round-up carries out of m (m==10'h3FF), then m becomes 0 and exp becomes exp+1. Maximum result exponent is 30, so Inf/NaN are never produced.
  - flt_o<={sign,exp,m}; next state is DONE.
- DONE (one cycle): done_o=1, busy_o=1. Next state is IDLE, where busy_o returns to 0.
- start_i while busy_o=1 is ignored: no queuing and no effect on the current conversion.
- start_i asserted in the DONE cycle is ignored. It is accepted only from IDLE, at the earliest one cycle after done_o.
- Latency: with leading-one position p (0..14) and accepting edge N, done_o is high in cycle N+(14-p)+3.
  - Worst case: magnitude 1 gives done_o in cycle N+17.
  - Best case: any p=14 magnitude gives done_o in cycle N+3.
  - Zero magnitude gives done_o in cycle N+1.
- flt_o changes only on the ROUND→DONE edge, the zero shortcut edge, or reset.
- Exponent arithmetic is 5-bit unsigned with no wrap possible in the legal range. The round increment is 11-bit internally to detect the carry.

Test Plan:
- Reset, then int_i=16'h0001, start pulse:
  - 14 NORM shifts;
  - done_o exactly 17 cycles after the accepting edge;
  - flt_o=16'h3C00 (1.0).
- int_i=16'h8000 (negative zero): done_o 1 cycle after accept, flt_o=16'h8000. int_i=16'h0000 gives flt_o=16'h0000.
- Saturating round carry: int_i=16'h7FFF gives flt_o=16'h7800 (32768: guard=1, sticky=1, mantissa carry into exp 30). int_i=16'h4000 gives 16'h7400 with no shifts.
- Ties to even:
  - 16'h0801 (2049) → 16'h6800 (2048, round down);
  - 16'h0803 (2051) → 16'h6802 (2052, round up);
  - 16'h8803 → 16'hE802.
- Handshake:
  - a second start_i pulse with different int_i during NORM is ignored; the first result completes unchanged;
  - start_i held continuously gives back-to-back conversions separated by one IDLE cycle;
  - flt_o stays stable between done pulses.
- Reset mid-operation:
  - drive reset_i=0 for one edge 5 cycles into converting 16'h0001;
  - no done_o pulse occurs, and busy_o=0 and flt_o=0 the next cycle;
  - a fresh start with 16'h0003 gives flt_o=16'h4200 (3.0).

Source files
------------

// File: rtl/int2flt_seq_if.sv
// Handshake and data bundle between the conversion controller and int2flt_seq.
// The controller (master) loads an operand and pulses start; the converter
// (slave) reports busy, a one-cycle done pulse and the half-float result.
interface int2flt_seq_if #(
  parameter int INT_W = 16
);
  logic             start_i;
  logic [INT_W-1:0] int_i;
  logic             busy_o;
  logic             done_o;
  logic [INT_W-1:0] flt_o;

  modport master (
    output start_i,
    output int_i,
    input  busy_o,
    input  done_o,
    input  flt_o
  );

  modport slave (
    input  start_i,
    input  int_i,
    output busy_o,
    output done_o,
    output flt_o
  );
endinterface

// File: rtl/int2flt_seq.sv
// Sequential sign-magnitude integer to IEEE-754 half-precision converter.
// The magnitude is normalised by one left shift per cycle until its leading
// one reaches the hidden-bit position, then rounded to nearest-even in a
// single cycle. A zero magnitude skips straight to DONE so that the sign of
// zero is kept. Exponent never leaves [BIAS, BIAS+15], so no Inf/NaN result.
module int2flt_seq #(
  parameter int INT_W  = 16,
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10,
  parameter int BIAS   = 15
) (
  input  logic          clk_i,
  input  logic          reset_i,
  int2flt_seq_if.slave  bus
);

  localparam int MAG_W = INT_W - 1;
  // bit index of the guard bit once the leading one sits at mag[MAG_W-1]
  localparam int GRD_B = MAG_W - 2 - MANT_W;
  // exponent matching a leading one at mag[MAG_W-1] before any shift
  localparam logic [EXP_W-1:0] EXP_INIT = EXP_W'(BIAS + MAG_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state_r, state_s;
  logic               sign_r, sign_s;
  logic [MAG_W-1:0]   mag_r, mag_s;
  logic [EXP_W-1:0]   exp_r, exp_s;
  logic [INT_W-1:0]   flt_r, flt_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;

  // Round-to-nearest-even on the normalised fraction (hidden bit excluded)
  // and pack. A carry out of the mantissa bumps the exponent by one and
  // clears the stored mantissa.
  function automatic logic [INT_W-1:0] round_pack(
    input logic             sign,
    input logic [EXP_W-1:0] exp_v,
    input logic [MAG_W-2:0] frac
  );
    logic [MANT_W-1:0] m;
    logic              guard;
    logic              sticky;
    logic              inc;
    logic [MANT_W:0]   sum;
    m      = frac[MAG_W-2 -: MANT_W];
    guard  = frac[GRD_B];
    sticky = |frac[GRD_B-1:0];
    inc    = guard & (sticky | m[0]);
    sum    = {1'b0, m} + {{MANT_W{1'b0}}, inc};
    if (sum[MANT_W]) begin
      round_pack = {sign, exp_v + {{(EXP_W-1){1'b0}}, 1'b1}, {MANT_W{1'b0}}};
    end else begin
      round_pack = {sign, exp_v, sum[MANT_W-1:0]};
    end
  endfunction

  // Next-state, datapath and output decode for the conversion FSM.
  always_comb begin
    state_s = state_r;
    sign_s  = sign_r;
    mag_s   = mag_r;
    exp_s   = exp_r;
    flt_s   = flt_r;
    case (state_r)
      IDLE: begin
        if (bus.start_i) begin
          sign_s = bus.int_i[INT_W-1];
          mag_s  = bus.int_i[MAG_W-1:0];
          exp_s  = EXP_INIT;
          if (bus.int_i[MAG_W-1:0] == {MAG_W{1'b0}}) begin
            flt_s   = {bus.int_i[INT_W-1], {(INT_W-1){1'b0}}};
            state_s = DONE;
          end else begin
            state_s = NORM;
          end
        end else begin
          state_s = IDLE;
        end
      end
      NORM: begin
        if (mag_r[MAG_W-1]) begin
          state_s = ROUND;
        end else begin
          mag_s = {mag_r[MAG_W-2:0], 1'b0};
          exp_s = exp_r - {{(EXP_W-1){1'b0}}, 1'b1};
        end
      end
      ROUND: begin
        flt_s   = round_pack(sign_r, exp_r, mag_r[MAG_W-2:0]);
        state_s = DONE;
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
    busy_s = (state_s != IDLE);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
      sign_r  <= 1'b0;
      mag_r   <= {MAG_W{1'b0}};
      exp_r   <= {EXP_W{1'b0}};
      flt_r   <= {INT_W{1'b0}};
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sign_r  <= sign_s;
      mag_r   <= mag_s;
      exp_r   <= exp_s;
      flt_r   <= flt_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.busy_o = busy_r;
  assign bus.done_o = done_r;
  assign bus.flt_o  = flt_r;

endmodule

// File: tb/tb_int2flt_seq.sv
// Self-checking bench for int2flt_seq: directed cases, randomized operands
// against an arithmetic reference model, handshake and mid-run reset.
module tb_int2flt_seq;

  logic clk = 1'b0;
  logic reset_i = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  int2flt_seq_if #(.INT_W(16)) bus_if ();

  int2flt_seq dut (
    .clk_i   (clk),
    .reset_i (reset_i),
    .bus     (bus_if)
  );

  // Reference: value-level conversion with explicit nearest-even rounding.
  function automatic logic [15:0] model_flt(input logic [15:0] v);
    int mag, p, e, q, sh, rem, half;
    logic [4:0] ev;
    logic [9:0] mv;
    mag = int'(v[14:0]);
    if (mag == 0) return {v[15], 15'd0};
    p = 0;
    for (int i = 0; i < 15; i++) if (mag >= (1 << i)) p = i;
    e = 15 + p;
    if (p <= 10) begin
      q = mag << (10 - p);
    end else begin
      sh   = p - 10;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 1 << (sh - 1);
      if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        e = e + 1;
      end
    end
    ev = e[4:0];
    mv = q[9:0];
    return {v[15], ev, mv};
  endfunction

  // Reference latency: edges from the accepting edge up to done visible.
  function automatic int model_lat(input logic [15:0] v);
    int mag, p;
    mag = int'(v[14:0]);
    if (mag == 0) return 1;
    p = 0;
    for (int i = 0; i < 15; i++) if (mag >= (1 << i)) p = i;
    return 17 - p;
  endfunction

  // Drive one conversion and collect result, latency and busy/done behaviour.
  task automatic run_conv(input logic [15:0] v, output logic [15:0] res,
                          output int lat, output bit busy_ok, output bit after_ok);
    int g;
    @(negedge clk);
    g = 0;
    while (bus_if.busy_o && g < 40) begin
      @(negedge clk);
      g++;
    end
    bus_if.start_i = 1'b1;
    bus_if.int_i   = v;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    bus_if.int_i   = 16'($urandom);
    lat = 1;
    busy_ok = bus_if.busy_o;
    while (!bus_if.done_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (!bus_if.busy_o) busy_ok = 1'b0;
    end
    if (!bus_if.done_o) lat = -1;
    res = bus_if.flt_o;
    @(posedge clk); #1;
    after_ok = !bus_if.done_o && !bus_if.busy_o && (bus_if.flt_o === res);
  endtask

  task automatic test_reset();
    reset_i = 1'b0;
    bus_if.start_i = 1'b1;
    bus_if.int_i   = 16'h1234;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0 || bus_if.flt_o !== 16'h0000) begin
      failures++;
      $display("FAIL reset_state: busy=%b done=%b flt=%h, required 0 0 0000",
               bus_if.busy_o, bus_if.done_o, bus_if.flt_o);
    end
    @(negedge clk);
    bus_if.start_i = 1'b0;
    reset_i = 1'b1;
  endtask

  task automatic test_directed();
    logic [15:0] vin [8]  = '{16'h0001, 16'h8000, 16'h0000, 16'h7FFF,
                              16'h4000, 16'h0801, 16'h0803, 16'h8803};
    logic [15:0] vexp [8] = '{16'h3C00, 16'h8000, 16'h0000, 16'h7800,
                              16'h7400, 16'h6800, 16'h6802, 16'hE802};
    int          lexp [8] = '{17, 1, 1, 3, 3, 6, 6, 6};
    logic [15:0] res;
    int lat;
    bit bok, aok;
    for (int i = 0; i < 8; i++) begin
      run_conv(vin[i], res, lat, bok, aok);
      checks++;
      if (res !== vexp[i]) begin
        failures++;
        $display("FAIL directed_flt in=%h: got %h, required %h", vin[i], res, vexp[i]);
      end
      checks++;
      if (lat != lexp[i]) begin
        failures++;
        $display("FAIL directed_lat in=%h: got %0d, required %0d", vin[i], lat, lexp[i]);
      end
      checks++;
      if (!bok || !aok) begin
        failures++;
        $display("FAIL directed_handshake in=%h: busy_ok=%b after_ok=%b, required 1 1",
                 vin[i], bok, aok);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] v, res;
    int lat;
    bit bok, aok;
    for (int i = 0; i < 60; i++) begin
      v = {1'($urandom), 15'($urandom) >> $urandom_range(0, 14)};
      run_conv(v, res, lat, bok, aok);
      checks++;
      if (res !== model_flt(v) || lat != model_lat(v) || !bok || !aok) begin
        failures++;
        $display("FAIL random in=%h: flt=%h lat=%0d busy_ok=%b after_ok=%b, required flt=%h lat=%0d 1 1",
                 v, res, lat, bok, aok, model_flt(v), model_lat(v));
      end
    end
  endtask

  task automatic test_ignore_start();
    logic [15:0] prev;
    int t;
    bit stable;
    @(negedge clk);
    while (bus_if.busy_o) @(negedge clk);
    prev = bus_if.flt_o;
    bus_if.start_i = 1'b1;
    bus_if.int_i   = 16'h0001;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    t = 1;
    stable = 1'b1;
    while (!bus_if.done_o && t < 40) begin
      @(negedge clk);
      if (t == 3 || t == 7) begin
        bus_if.start_i = 1'b1;
        bus_if.int_i   = 16'h7FFF;
      end else begin
        bus_if.start_i = 1'b0;
      end
      @(posedge clk); #1;
      t++;
      if (!bus_if.done_o && bus_if.flt_o !== prev) stable = 1'b0;
    end
    bus_if.start_i = 1'b0;
    checks++;
    if (t != 17 || bus_if.flt_o !== 16'h3C00) begin
      failures++;
      $display("FAIL ignore_start: lat=%0d flt=%h, required 17 3c00", t, bus_if.flt_o);
    end
    checks++;
    if (!stable) begin
      failures++;
      $display("FAIL flt_stable_during_conv: flt changed before done, required hold at %h", prev);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] vals [6];
    logic [15:0] last;
    int t, prev_t, exp_t;
    bit stable;
    vals[0] = 16'h4000;
    vals[1] = 16'h0000;
    vals[2] = {1'($urandom), 15'($urandom)};
    vals[3] = {1'($urandom), 15'($urandom) >> 8};
    vals[4] = 16'h0001;
    vals[5] = 16'h8803;
    @(negedge clk);
    while (bus_if.busy_o) @(negedge clk);
    last = bus_if.flt_o;
    bus_if.start_i = 1'b1;
    bus_if.int_i   = vals[0];
    @(posedge clk); #1;
    t = 1;
    prev_t = 0;
    for (int k = 0; k < 6; k++) begin
      exp_t = (k == 0) ? model_lat(vals[0]) : prev_t + model_lat(vals[k]) + 1;
      stable = 1'b1;
      while (!bus_if.done_o && t < 400) begin
        @(posedge clk); #1;
        t++;
        if (!bus_if.done_o && bus_if.flt_o !== last) stable = 1'b0;
      end
      if (k < 5) bus_if.int_i = vals[k+1];
      else bus_if.start_i = 1'b0;
      checks++;
      if (t != exp_t || bus_if.flt_o !== model_flt(vals[k]) || !stable) begin
        failures++;
        $display("FAIL back_to_back k=%0d in=%h: done_at=%0d flt=%h stable=%b, required %0d %h 1",
                 k, vals[k], t, bus_if.flt_o, stable, exp_t, model_flt(vals[k]));
      end
      last = bus_if.flt_o;
      prev_t = t;
      @(posedge clk); #1;
      t++;
    end
    bus_if.start_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [15:0] res;
    int lat;
    bit bok, aok, no_done;
    @(negedge clk);
    while (bus_if.busy_o) @(negedge clk);
    bus_if.start_i = 1'b1;
    bus_if.int_i   = 16'h0001;
    @(posedge clk); #1;
    bus_if.start_i = 1'b0;
    no_done = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus_if.done_o) no_done = 1'b0;
    end
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus_if.busy_o !== 1'b0 || bus_if.done_o !== 1'b0 || bus_if.flt_o !== 16'h0000) begin
      failures++;
      $display("FAIL mid_reset_state: busy=%b done=%b flt=%h, required 0 0 0000",
               bus_if.busy_o, bus_if.done_o, bus_if.flt_o);
    end
    @(negedge clk);
    reset_i = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus_if.done_o || bus_if.busy_o) no_done = 1'b0;
    end
    checks++;
    if (!no_done) begin
      failures++;
      $display("FAIL mid_reset_no_done: done/busy seen after reset, required none");
    end
    run_conv(16'h0003, res, lat, bok, aok);
    checks++;
    if (res !== 16'h4200 || lat != 16 || !bok || !aok) begin
      failures++;
      $display("FAIL mid_reset_restart: flt=%h lat=%0d busy_ok=%b after_ok=%b, required 4200 16 1 1",
               res, lat, bok, aok);
    end
  endtask

  initial begin
    bus_if.start_i = 1'b0;
    bus_if.int_i   = 16'h0000;
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
